// File: rtl/pe_sequencer.sv
// pe_sequencer: drives one processing element through a dot-product job (CLR/PASS, MAC x K, RND, OUT)
package pe_pkg;
    localparam int PE_INPUT_BITWIDTH = 32;
    typedef logic [1:0] pe_mode_t;
    typedef logic [4:0] pe_value_t;
    localparam pe_mode_t MODE_INT8  = 2'd0;
    localparam pe_mode_t MODE_INT16 = 2'd1;
    localparam pe_mode_t MODE_INT32 = 2'd2;
    typedef struct packed {
        pe_mode_t   mode;
        logic [1:0] opcode;
        pe_value_t  value;
    } pe_inst_t;
    localparam logic [1:0] PE_RND_OPCODE = 2'd1;
    localparam pe_value_t  PE_CLR_VALUE  = 5'd1;
    localparam pe_value_t  PE_PASS_VALUE = 5'd2;
    localparam pe_value_t  PE_MAC_VALUE  = 5'd3;
    localparam pe_value_t  PE_OUT_VALUE  = 5'd4;
endpackage

module pe_sequencer
    import pe_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  pe_mode_t                     cmd_mode,
    input  logic [LEN_W-1:0]             cmd_len,
    input  logic                         cmd_preload,
    input  logic [PE_INPUT_BITWIDTH-1:0] cmd_bias,
    input  pe_value_t                    cmd_shift,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [PE_INPUT_BITWIDTH-1:0] op_vec,
    input  logic [PE_INPUT_BITWIDTH-1:0] op_mat,
    output pe_inst_t                     pe_inst,
    output logic                         pe_inst_valid,
    output logic [PE_INPUT_BITWIDTH-1:0] pe_vector,
    output logic [PE_INPUT_BITWIDTH-1:0] pe_matrix,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic                         busy
);
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_MAC, S_RND, S_OUT, S_DRAIN, S_RESP} state_t;

    state_t                       r_state;
    pe_mode_t                     r_mode;
    logic [LEN_W-1:0]             r_cnt;
    logic                         r_preload;
    pe_value_t                    r_shift;
    logic [PE_INPUT_BITWIDTH-1:0] r_bias;
    logic [PE_INPUT_BITWIDTH-1:0] r_vector;
    logic [PE_INPUT_BITWIDTH-1:0] r_matrix;
    logic                         w_pop;
    state_t                       w_post;
    pe_inst_t                     w_inst;

    assign w_pop  = (r_state == S_MAC) && op_valid;
    assign w_post = (r_shift != '0) ? S_RND : S_OUT;

    // Job FSM: latch the command, count pops down from K, stage operands one cycle ahead of the PE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mode    <= '0;
            r_cnt     <= '0;
            r_preload <= 1'b0;
            r_shift   <= '0;
            r_bias    <= '0;
            r_vector  <= '0;
            r_matrix  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (cmd_valid) begin
                    r_mode    <= cmd_mode;
                    r_cnt     <= cmd_len;
                    r_preload <= cmd_preload;
                    r_shift   <= cmd_shift;
                    r_bias    <= cmd_bias;
                    r_state   <= S_INIT;
                end
                S_INIT: begin
                    r_vector <= r_bias;
                    r_state  <= (r_cnt != '0) ? S_MAC : w_post;
                end
                S_MAC: if (op_valid) begin
                    r_vector <= op_vec;
                    r_matrix <= op_mat;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == LEN_W'(1)) r_state <= w_post;
                end
                S_RND:   r_state <= S_OUT;
                S_OUT:   r_state <= S_DRAIN;
                S_DRAIN: r_state <= S_RESP;
                S_RESP:  if (res_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Instruction decode from state; zero whenever nothing is issued, MAC only on a pop
    always_comb begin
        pe_inst_valid = (r_state == S_INIT) || (r_state == S_RND) || (r_state == S_OUT) || w_pop;
        w_inst        = '0;
        w_inst.mode   = pe_inst_valid ? r_mode : '0;
        w_inst.opcode = (r_state == S_RND) ? PE_RND_OPCODE : 2'd0;
        w_inst.value  = (r_state == S_INIT) ? (r_preload ? PE_PASS_VALUE : PE_CLR_VALUE) :
                        w_pop               ? PE_MAC_VALUE :
                        (r_state == S_RND)  ? r_shift :
                        (r_state == S_OUT)  ? PE_OUT_VALUE : '0;
    end

    assign pe_inst   = w_inst;
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign op_ready  = (r_state == S_MAC);
    assign res_valid = (r_state == S_RESP);
    assign pe_vector = r_vector;
    assign pe_matrix = r_matrix;
endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer: directed scenario tasks with a small behavioral PE fed by the sequencer
module tb_pe_sequencer;
    import pe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    pe_mode_t    cmd_mode = '0;
    logic [15:0] cmd_len = '0;
    logic        cmd_preload = 1'b0;
    logic [31:0] cmd_bias = '0;
    pe_value_t   cmd_shift = '0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [31:0] op_vec = '0;
    logic [31:0] op_mat = '0;
    pe_inst_t    pe_inst;
    logic        pe_inst_valid;
    logic [31:0] pe_vector;
    logic [31:0] pe_matrix;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        busy;

    int errs = 0;
    int checks = 0;

    pe_sequencer #(.LEN_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
        .cmd_preload(cmd_preload), .cmd_bias(cmd_bias), .cmd_shift(cmd_shift),
        .op_valid(op_valid), .op_ready(op_ready), .op_vec(op_vec), .op_mat(op_mat),
        .pe_inst(pe_inst), .pe_inst_valid(pe_inst_valid), .pe_vector(pe_vector), .pe_matrix(pe_matrix),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Behavioral PE: one-cycle instruction register, executes with the data present in the following cycle
    int               pops = 0;
    logic             m_v = 1'b0;
    pe_inst_t         m_inst = '0;
    logic [31:0]      m_out = '0;
    logic signed [31:0] acc [4];

    function automatic logic signed [31:0] lane(logic [31:0] v, pe_mode_t m, int i);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = v[i*8 +: 8];
        h = v[(i%2)*16 +: 16];
        if (m == MODE_INT8) return 32'(b);
        if (m == MODE_INT16) return (i < 2) ? 32'(h) : 32'sd0;
        return (i == 0) ? signed'(v) : 32'sd0;
    endfunction

    function automatic pe_inst_t mk(pe_mode_t m, logic [1:0] o, pe_value_t v);
        return {m, o, v};
    endfunction

    always @(posedge clk) begin
        pops   <= pops + ((op_valid && op_ready) ? 1 : 0);
        m_v    <= pe_inst_valid;
        m_inst <= pe_inst;
        if (m_v) begin
            for (int i = 0; i < 4; i++) begin
                if (m_inst.opcode == PE_RND_OPCODE) acc[i] <= acc[i] >>> m_inst.value;
                else if (m_inst.value == PE_CLR_VALUE) acc[i] <= 32'sd0;
                else if (m_inst.value == PE_PASS_VALUE) acc[i] <= lane(pe_vector, m_inst.mode, i);
                else if (m_inst.value == PE_MAC_VALUE)
                    acc[i] <= acc[i] + lane(pe_vector, m_inst.mode, i) * lane(pe_matrix, m_inst.mode, i);
            end
            if (m_inst.opcode == 2'd0 && m_inst.value == PE_OUT_VALUE)
                m_out <= (m_inst.mode == MODE_INT8)  ? {acc[3][7:0], acc[2][7:0], acc[1][7:0], acc[0][7:0]} :
                         (m_inst.mode == MODE_INT16) ? {acc[1][15:0], acc[0][15:0]} : acc[0];
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++; if ({cmd_ready, busy, op_ready, pe_inst_valid, res_valid, pe_inst, pe_vector, pe_matrix} !== {1'b1, 77'd0}) begin
            errs++; $display("FAIL reset_outputs got=%h exp=%h", {cmd_ready, busy, op_ready, pe_inst_valid, res_valid, pe_inst, pe_vector, pe_matrix}, {1'b1, 77'd0});
        end
        step;
        rst = 1'b0;
        step; #1;
        checks++; if ({cmd_ready, busy, pe_inst_valid} !== 3'b100) begin
            errs++; $display("FAIL reset_release got=%b exp=100", {cmd_ready, busy, pe_inst_valid});
        end
    endtask

    task automatic test_basic;
        step;
        cmd_valid = 1'b1; cmd_mode = MODE_INT32; cmd_len = 16'd2; cmd_preload = 1'b0; cmd_bias = 32'hdead; cmd_shift = 5'd0;
        op_valid = 1'b1; op_vec = 32'd3; op_mat = 32'd4;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL basic_accept got=%b exp=1", cmd_ready); end
        step; cmd_valid = 1'b0; #1;
        checks++; if ({pe_inst_valid, op_ready, pe_inst} !== {2'b10, mk(MODE_INT32, 2'd0, PE_CLR_VALUE)}) begin
            errs++; $display("FAIL basic_c1_clr got=%h exp=%h", {pe_inst_valid, op_ready, pe_inst}, {2'b10, mk(MODE_INT32, 2'd0, PE_CLR_VALUE)});
        end
        step; #1;
        checks++; if ({pe_inst_valid, op_ready, pe_inst} !== {2'b11, mk(MODE_INT32, 2'd0, PE_MAC_VALUE)}) begin
            errs++; $display("FAIL basic_c2_mac got=%h exp=%h", {pe_inst_valid, op_ready, pe_inst}, {2'b11, mk(MODE_INT32, 2'd0, PE_MAC_VALUE)});
        end
        step; op_vec = 32'd5; op_mat = 32'd6; #1;
        checks++; if ({pe_inst_valid, op_ready, pe_inst, pe_vector, pe_matrix} !== {2'b11, mk(MODE_INT32, 2'd0, PE_MAC_VALUE), 32'd3, 32'd4}) begin
            errs++; $display("FAIL basic_c3_mac_data got=%h exp=%h", {pe_inst_valid, op_ready, pe_inst, pe_vector, pe_matrix}, {2'b11, mk(MODE_INT32, 2'd0, PE_MAC_VALUE), 32'd3, 32'd4});
        end
        step; op_valid = 1'b0; #1;
        checks++; if ({pe_inst_valid, op_ready, pe_inst, pe_vector, pe_matrix} !== {2'b10, mk(MODE_INT32, 2'd0, PE_OUT_VALUE), 32'd5, 32'd6}) begin
            errs++; $display("FAIL basic_c4_out got=%h exp=%h", {pe_inst_valid, op_ready, pe_inst, pe_vector, pe_matrix}, {2'b10, mk(MODE_INT32, 2'd0, PE_OUT_VALUE), 32'd5, 32'd6});
        end
        step; #1;
        checks++; if ({pe_inst_valid, pe_inst, res_valid, busy} !== {1'b0, 9'd0, 2'b01}) begin
            errs++; $display("FAIL basic_c5_drain got=%h exp=%h", {pe_inst_valid, pe_inst, res_valid, busy}, {1'b0, 9'd0, 2'b01});
        end
        step; res_ready = 1'b1; #1;
        checks++; if ({res_valid, m_out} !== {1'b1, 32'd42}) begin
            errs++; $display("FAIL basic_c6_result got=%h exp=%h", {res_valid, m_out}, {1'b1, 32'd42});
        end
        step; res_ready = 1'b0; #1;
        checks++; if ({cmd_ready, res_valid, busy} !== 3'b100) begin
            errs++; $display("FAIL basic_c7_idle got=%b exp=100", {cmd_ready, res_valid, busy});
        end
    endtask

    task automatic test_rnd_int8;
        step;
        cmd_valid = 1'b1; cmd_mode = MODE_INT8; cmd_len = 16'd1; cmd_preload = 1'b1; cmd_bias = 32'h04030201; cmd_shift = 5'd1;
        op_valid = 1'b1; op_vec = 32'h01010101; op_mat = 32'h02020202;
        step; cmd_valid = 1'b0; #1;
        checks++; if ({pe_inst_valid, pe_inst} !== {1'b1, mk(MODE_INT8, 2'd0, PE_PASS_VALUE)}) begin
            errs++; $display("FAIL rnd_c1_pass got=%h exp=%h", {pe_inst_valid, pe_inst}, {1'b1, mk(MODE_INT8, 2'd0, PE_PASS_VALUE)});
        end
        step; #1;
        checks++; if ({pe_inst_valid, pe_inst, pe_vector} !== {1'b1, mk(MODE_INT8, 2'd0, PE_MAC_VALUE), 32'h04030201}) begin
            errs++; $display("FAIL rnd_c2_mac_bias got=%h exp=%h", {pe_inst_valid, pe_inst, pe_vector}, {1'b1, mk(MODE_INT8, 2'd0, PE_MAC_VALUE), 32'h04030201});
        end
        step; op_valid = 1'b0; #1;
        checks++; if ({pe_inst_valid, op_ready, pe_inst} !== {2'b10, mk(MODE_INT8, PE_RND_OPCODE, 5'd1)}) begin
            errs++; $display("FAIL rnd_c3_rnd got=%h exp=%h", {pe_inst_valid, op_ready, pe_inst}, {2'b10, mk(MODE_INT8, PE_RND_OPCODE, 5'd1)});
        end
        step; #1;
        checks++; if ({pe_inst_valid, pe_inst} !== {1'b1, mk(MODE_INT8, 2'd0, PE_OUT_VALUE)}) begin
            errs++; $display("FAIL rnd_c4_out got=%h exp=%h", {pe_inst_valid, pe_inst}, {1'b1, mk(MODE_INT8, 2'd0, PE_OUT_VALUE)});
        end
        step; #1;
        checks++; if (res_valid !== 1'b0) begin errs++; $display("FAIL rnd_c5_early got=%b exp=0", res_valid); end
        step; res_ready = 1'b1; #1;
        checks++; if ({res_valid, m_out} !== {1'b1, 32'h03020201}) begin
            errs++; $display("FAIL rnd_c6_result got=%h exp=%h", {res_valid, m_out}, {1'b1, 32'h03020201});
        end
        step; res_ready = 1'b0;
    endtask

    task automatic test_bubbles;
        logic [4:0] pv;
        int p0;
        pv = 5'b11001;
        step;
        cmd_valid = 1'b1; cmd_mode = MODE_INT32; cmd_len = 16'd3; cmd_preload = 1'b0; cmd_shift = 5'd0; op_valid = 1'b0;
        step; cmd_valid = 1'b0; p0 = pops;
        for (int i = 0; i < 5; i++) begin
            step;
            op_valid = pv[i];
            op_vec = pv[i] ? ((i == 0) ? 32'd1 : 32'(i - 1)) : 32'd99;
            op_mat = op_vec;
            #1;
            checks++; if ({pe_inst_valid, op_ready} !== {pv[i], 1'b1}) begin
                errs++; $display("FAIL bubble_c%0d got=%b exp=%b", i + 2, {pe_inst_valid, op_ready}, {pv[i], 1'b1});
            end
        end
        step; op_valid = 1'b1; #1;
        checks++; if ({pe_inst_valid, op_ready, pe_inst} !== {2'b10, mk(MODE_INT32, 2'd0, PE_OUT_VALUE)}) begin
            errs++; $display("FAIL bubble_c7_out got=%h exp=%h", {pe_inst_valid, op_ready, pe_inst}, {2'b10, mk(MODE_INT32, 2'd0, PE_OUT_VALUE)});
        end
        step; op_valid = 1'b0; #1;
        checks++; if (res_valid !== 1'b0) begin errs++; $display("FAIL bubble_c8_early got=%b exp=0", res_valid); end
        step; res_ready = 1'b1; #1;
        checks++; if ({res_valid, m_out} !== {1'b1, 32'd14}) begin
            errs++; $display("FAIL bubble_c9_result got=%h exp=%h", {res_valid, m_out}, {1'b1, 32'd14});
        end
        checks++; if (pops - p0 !== 3) begin errs++; $display("FAIL bubble_pops got=%0d exp=3", pops - p0); end
        step; res_ready = 1'b0;
    endtask

    task automatic test_k0;
        int p0;
        step;
        cmd_valid = 1'b1; cmd_mode = MODE_INT16; cmd_len = 16'd0; cmd_preload = 1'b1; cmd_bias = 32'h0007FFFB; cmd_shift = 5'd0;
        op_valid = 1'b1; op_vec = 32'd77; op_mat = 32'd77; p0 = pops;
        step; cmd_valid = 1'b0; #1;
        checks++; if ({pe_inst_valid, op_ready, pe_inst} !== {2'b10, mk(MODE_INT16, 2'd0, PE_PASS_VALUE)}) begin
            errs++; $display("FAIL k0_c1_pass got=%h exp=%h", {pe_inst_valid, op_ready, pe_inst}, {2'b10, mk(MODE_INT16, 2'd0, PE_PASS_VALUE)});
        end
        step; #1;
        checks++; if ({pe_inst_valid, op_ready, pe_inst} !== {2'b10, mk(MODE_INT16, 2'd0, PE_OUT_VALUE)}) begin
            errs++; $display("FAIL k0_c2_out got=%h exp=%h", {pe_inst_valid, op_ready, pe_inst}, {2'b10, mk(MODE_INT16, 2'd0, PE_OUT_VALUE)});
        end
        step; #1;
        step; res_ready = 1'b1; #1;
        checks++; if ({res_valid, m_out} !== {1'b1, 32'h0007FFFB}) begin
            errs++; $display("FAIL k0_c4_result got=%h exp=%h", {res_valid, m_out}, {1'b1, 32'h0007FFFB});
        end
        checks++; if (pops !== p0) begin errs++; $display("FAIL k0_pops got=%0d exp=0", pops - p0); end
        step; res_ready = 1'b0; op_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        step;
        cmd_valid = 1'b1; cmd_mode = MODE_INT32; cmd_len = 16'd0; cmd_preload = 1'b0; cmd_shift = 5'd0;
        step;
        cmd_mode = MODE_INT8; cmd_len = 16'd1; #1;
        checks++; if (cmd_ready !== 1'b0) begin errs++; $display("FAIL b2b_busy_ready got=%b exp=0", cmd_ready); end
        step; step;
        for (int i = 0; i < 5; i++) begin
            step; #1;
            checks++; if ({res_valid, cmd_ready, busy} !== 3'b101) begin
                errs++; $display("FAIL b2b_hold%0d got=%b exp=101", i, {res_valid, cmd_ready, busy});
            end
        end
        step; res_ready = 1'b1; #1;
        checks++; if (res_valid !== 1'b1) begin errs++; $display("FAIL b2b_handshake got=%b exp=1", res_valid); end
        step; op_valid = 1'b1; op_vec = 32'h01020304; op_mat = 32'h01010101; #1;
        checks++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL b2b_reaccept got=%b exp=1", cmd_ready); end
        step; cmd_valid = 1'b0; #1;
        checks++; if ({pe_inst_valid, pe_inst} !== {1'b1, mk(MODE_INT8, 2'd0, PE_CLR_VALUE)}) begin
            errs++; $display("FAIL b2b_init got=%h exp=%h", {pe_inst_valid, pe_inst}, {1'b1, mk(MODE_INT8, 2'd0, PE_CLR_VALUE)});
        end
        step; step; op_valid = 1'b0;
        step; step; #1;
        checks++; if ({res_valid, m_out} !== {1'b1, 32'h01020304}) begin
            errs++; $display("FAIL b2b_result got=%h exp=%h", {res_valid, m_out}, {1'b1, 32'h01020304});
        end
        step; res_ready = 1'b0; #1;
        checks++; if ({cmd_ready, busy} !== 2'b10) begin errs++; $display("FAIL b2b_done got=%b exp=10", {cmd_ready, busy}); end
    endtask

    task automatic test_reset_mid;
        int p0;
        step;
        cmd_valid = 1'b1; cmd_mode = MODE_INT32; cmd_len = 16'd4; cmd_preload = 1'b0; cmd_shift = 5'd0;
        op_valid = 1'b1; op_vec = 32'd9; op_mat = 32'd9; p0 = pops;
        step; cmd_valid = 1'b0;
        step;
        step; #1;
        checks++; if ({op_ready, pe_vector} !== {1'b1, 32'd9}) begin
            errs++; $display("FAIL rstmid_pre got=%h exp=%h", {op_ready, pe_vector}, {1'b1, 32'd9});
        end
        rst = 1'b1; #1;
        checks++; if ({cmd_ready, busy, op_ready, pe_inst_valid, res_valid, pe_inst, pe_vector, pe_matrix} !== {1'b1, 77'd0}) begin
            errs++; $display("FAIL rstmid_outputs got=%h exp=%h", {cmd_ready, busy, op_ready, pe_inst_valid, res_valid, pe_inst, pe_vector, pe_matrix}, {1'b1, 77'd0});
        end
        checks++; if (pops - p0 !== 1) begin errs++; $display("FAIL rstmid_pops got=%0d exp=1", pops - p0); end
        step; step; rst = 1'b0; op_valid = 1'b0;
        step;
        cmd_valid = 1'b1; cmd_len = 16'd1; cmd_shift = 5'd2; op_valid = 1'b1; op_vec = 32'd7; op_mat = 32'd6;
        step; cmd_valid = 1'b0; #1;
        checks++; if ({pe_inst_valid, pe_inst} !== {1'b1, mk(MODE_INT32, 2'd0, PE_CLR_VALUE)}) begin
            errs++; $display("FAIL rstmid_init got=%h exp=%h", {pe_inst_valid, pe_inst}, {1'b1, mk(MODE_INT32, 2'd0, PE_CLR_VALUE)});
        end
        step; step; op_valid = 1'b0; #1;
        checks++; if ({pe_inst_valid, pe_inst} !== {1'b1, mk(MODE_INT32, PE_RND_OPCODE, 5'd2)}) begin
            errs++; $display("FAIL rstmid_rnd got=%h exp=%h", {pe_inst_valid, pe_inst}, {1'b1, mk(MODE_INT32, PE_RND_OPCODE, 5'd2)});
        end
        step; step; step; res_ready = 1'b1; #1;
        checks++; if ({res_valid, m_out} !== {1'b1, 32'd10}) begin
            errs++; $display("FAIL rstmid_result got=%h exp=%h", {res_valid, m_out}, {1'b1, 32'd10});
        end
        step; res_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_rnd_int8;
        test_bubbles;
        test_k0;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
